// File: rtl/key_bounce_gen_if.sv
// Request/status bundle of the bouncing-key generator: start request with hold length
// from the controller side, ready/busy/key level/done pulse back from the generator.
interface key_bounce_gen_if;
  logic       start;
  logic [7:0] hold_ticks;
  logic       ready;
  logic       busy;
  logic       key_n;
  logic       done;

  modport master (
    output start, hold_ticks,
    input  ready, busy, key_n, done
  );

  modport slave (
    input  start, hold_ticks,
    output ready, busy, key_n, done
  );
endinterface

// File: rtl/key_bounce_gen.sv
// key_bounce_gen: one active-low key press per accepted start, timed in prescaled ticks.
// Define KEY_BOUNCE_GEN_BOUNCE_EN for LFSR-driven press/release bounce; otherwise a clean press.
module key_bounce_gen #(
  parameter int          TICK_DIV   = 50_000,
  parameter int          BOUNCE_W   = 2,
  parameter int          BOUNCE_CNT = 3,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  key_bounce_gen_if.slave bus
);
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int CNT_W = (BOUNCE_W + 1 > 8) ? BOUNCE_W + 1 : 8;

  typedef enum logic [2:0] {IDLE, PRESS_B, HOLD, REL_B, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] seg_cnt;
  logic [CNT_W-1:0] seg_val;
  logic             seg_load;
  logic             accept;
  logic             tick;
  logic             seg_end;
  logic [7:0]       hold_eff;

  if (TICK_DIV < 2 || BOUNCE_CNT < 1 || SEED == 16'h0000) begin : g_param_check
    $error("key_bounce_gen: TICK_DIV >= 2, BOUNCE_CNT >= 1 and a nonzero SEED are required");
  end

  assign accept   = bus.start && (state == IDLE);
  assign tick     = (pre == PRE_W'(TICK_DIV - 1));
  assign seg_end  = tick && (seg_cnt == CNT_W'(1));
  assign hold_eff = (bus.hold_ticks == 8'd0) ? 8'd1 : bus.hold_ticks;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
  localparam int             IDX_W    = $clog2(2 * BOUNCE_CNT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * BOUNCE_CNT - 1);

  logic [15:0]      lfsr;
  logic [IDX_W-1:0] seg_idx;
  logic [7:0]       hold_q;
  logic             lfsr_adv;
  logic             idx_clr;
  logic             idx_inc;
  logic [CNT_W-1:0] rand_len;

  // Length is taken from the current LFSR value; the advance happens on the same load.
  assign rand_len = CNT_W'(lfsr[BOUNCE_W-1:0]) + CNT_W'(1);

  always_comb begin
    state_nxt = state;
    seg_load  = 1'b0;
    seg_val   = rand_len;
    lfsr_adv  = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    bus.ready = 1'b0;
    bus.busy  = 1'b1;
    bus.done  = 1'b0;
    bus.key_n = 1'b1;
    unique case (state)
      IDLE: begin
        bus.ready = 1'b1;
        bus.busy  = 1'b0;
        if (accept) begin
          state_nxt = PRESS_B;
          seg_load  = 1'b1;
          lfsr_adv  = 1'b1;
          idx_clr   = 1'b1;
        end
      end
      PRESS_B: begin
        // Even segment index is a low glitch, odd is the bounce back high.
        bus.key_n = seg_idx[0];
        if (seg_end) begin
          seg_load = 1'b1;
          if (seg_idx == IDX_LAST) begin
            state_nxt = HOLD;
            seg_val   = CNT_W'(hold_q);
          end else begin
            lfsr_adv = 1'b1;
            idx_inc  = 1'b1;
          end
        end
      end
      HOLD: begin
        bus.key_n = 1'b0;
        if (seg_end) begin
          state_nxt = REL_B;
          seg_load  = 1'b1;
          lfsr_adv  = 1'b1;
          idx_clr   = 1'b1;
        end
      end
      REL_B: begin
        bus.key_n = ~seg_idx[0];
        if (seg_end) begin
          if (seg_idx == IDX_LAST) begin
            state_nxt = DONE;
          end else begin
            seg_load = 1'b1;
            lfsr_adv = 1'b1;
            idx_inc  = 1'b1;
          end
        end
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= SEED;
      seg_idx <= '0;
      hold_q  <= 8'd1;
    end else begin
      if (lfsr_adv) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (idx_clr)      seg_idx <= '0;
      else if (idx_inc) seg_idx <= seg_idx + IDX_W'(1);
      if (accept) hold_q <= hold_eff;
    end
  end
`else
  always_comb begin
    state_nxt = state;
    seg_load  = 1'b0;
    seg_val   = CNT_W'(hold_eff);
    bus.ready = 1'b0;
    bus.busy  = 1'b1;
    bus.done  = 1'b0;
    bus.key_n = 1'b1;
    unique case (state)
      IDLE: begin
        bus.ready = 1'b1;
        bus.busy  = 1'b0;
        if (accept) begin
          state_nxt = HOLD;
          seg_load  = 1'b1;
        end
      end
      HOLD: begin
        bus.key_n = 1'b0;
        if (seg_end) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`endif

  // Prescaler is held at zero while idle, so every press starts on a fresh tick boundary.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) pre <= '0;
    else if (tick)            pre <= '0;
    else                      pre <= pre + PRE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                            seg_cnt <= '0;
    else if (seg_load)                  seg_cnt <= seg_val;
    else if (tick && seg_cnt != '0)     seg_cnt <= seg_cnt - CNT_W'(1);
  end
endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed bench for key_bounce_gen with TICK_DIV=4, BOUNCE_W=2, BOUNCE_CNT=2.
// Expected waveforms come from hand values and a small reference model of the press.
module tb_key_bounce_gen;
  localparam int          TD      = 4;
  localparam int          BW      = 2;
  localparam int          BC      = 2;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int          MAX_CYC = 2000;
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
  localparam int EXP_FALLS = 2 * BC + 1;
  localparam int LEAD_LOW  = 8;
`else
  localparam int EXP_FALLS = 1;
  localparam int LEAD_LOW  = 40;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic got_key[$];
  logic got_done[$];
  logic got_rdy[$];
  logic exp_key[$];
  int   exp_press_len = 0;
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
  logic [15:0] m_lfsr = SEED;
`endif

  always #5 clk = ~clk;

  key_bounce_gen_if bus();

  key_bounce_gen #(
    .TICK_DIV(TD), .BOUNCE_W(BW), .BOUNCE_CNT(BC), .SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Reference press: bounce segments from the model LFSR, stable hold, closing idle/done cycle.
  task automatic build_exp(input logic [7:0] h);
    int hh;
    hh = (h == 8'd0) ? 1 : int'(h);
    exp_key.delete();
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
    for (int s = 0; s < 2 * BC; s++) begin
      int len;
      len = (int'(m_lfsr[BW-1:0]) + 1) * TD;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      for (int c = 0; c < len; c++) exp_key.push_back(s % 2 == 1);
    end
`endif
    exp_press_len = exp_key.size();
    for (int c = 0; c < hh * TD; c++) exp_key.push_back(1'b0);
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
    for (int s = 0; s < 2 * BC; s++) begin
      int len;
      len = (int'(m_lfsr[BW-1:0]) + 1) * TD;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      for (int c = 0; c < len; c++) exp_key.push_back(s % 2 == 0);
    end
`endif
    exp_key.push_back(1'b1);
  endtask

  function automatic int first_diff();
    int n;
    n = (got_key.size() < exp_key.size()) ? got_key.size() : exp_key.size();
    for (int i = 0; i < n; i++) if (got_key[i] !== exp_key[i]) return i;
    return -1;
  endfunction

  function automatic int count_falls();
    int   f;
    logic prev;
    f = 0;
    prev = 1'b1;
    for (int i = 0; i < got_key.size(); i++) begin
      if (prev === 1'b1 && got_key[i] === 1'b0) f++;
      prev = got_key[i];
    end
    return f;
  endfunction

  function automatic int max_low_run();
    int best;
    int run;
    best = 0;
    run = 0;
    for (int i = 0; i < got_key.size(); i++) begin
      run = (got_key[i] === 1'b0) ? run + 1 : 0;
      if (run > best) best = run;
    end
    return best;
  endfunction

  function automatic int run_at(input int idx);
    int n;
    n = 0;
    while (idx + n < got_key.size() && got_key[idx + n] === 1'b0) n++;
    return n;
  endfunction

  function automatic int count_ones(input bit which_done);
    int n;
    n = 0;
    for (int i = 0; i < got_done.size(); i++)
      if ((which_done ? got_done[i] : got_rdy[i]) === 1'b1) n++;
    return n;
  endfunction

  task automatic start_press(input logic [7:0] h);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.hold_ticks = h;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Records from the cycle after acceptance through the done cycle; optional mid-run poke.
  task automatic capture(input int poke_at, input bit poke_rst, output bit cut);
    int i;
    bit stop;
    i = 0;
    stop = 1'b0;
    cut = 1'b0;
    got_key.delete();
    got_done.delete();
    got_rdy.delete();
    while (!stop) begin
      @(negedge clk);
      got_key.push_back(bus.key_n);
      got_done.push_back(bus.done);
      got_rdy.push_back(bus.ready);
      bus.start = 1'b0;
      if (bus.done === 1'b1 || i >= MAX_CYC) stop = 1'b1;
      else if (i == poke_at) begin
        if (poke_rst) begin
          rst  = 1'b1;
          cut  = 1'b1;
          stop = 1'b1;
        end else begin
          bus.start      = 1'b1;
          bus.hold_ticks = 8'd200;
        end
      end
      i++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    bus.hold_ticks = 8'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.key_n, bus.ready, bus.busy, bus.done} !== 4'b1100) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got key_n/ready/busy/done=%b want 1100", c,
                 {bus.key_n, bus.ready, bus.busy, bus.done});
      end
    end
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.key_n, bus.ready, bus.busy, bus.done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_release: got key_n/ready/busy/done=%b want 1100",
               {bus.key_n, bus.ready, bus.busy, bus.done});
    end
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
    m_lfsr = SEED;
`endif
  endtask

  task automatic test_single_press();
    bit cut;
    build_exp(8'd5);
    start_press(8'd5);
    capture(-1, 1'b0, cut);
    n_checks++;
    if (got_key.size() !== exp_key.size()) begin
      n_fail++;
      $display("FAIL single_len: got %0d cycles want %0d", got_key.size(), exp_key.size());
    end
    n_checks++;
    if (first_diff() != -1) begin
      n_fail++;
      $display("FAIL single_wave: key_n differs at cycle N+%0d, got %b want %b",
               first_diff() + 1, got_key[first_diff()], exp_key[first_diff()]);
    end
`ifndef KEY_BOUNCE_GEN_BOUNCE_EN
    n_checks++;
    if (got_key.size() != 21 || run_at(0) != 20) begin
      n_fail++;
      $display("FAIL clean_timing: done at N+%0d low run %0d, want done at N+21 low run 20",
               got_key.size(), run_at(0));
    end
`endif
    n_checks++;
    if (got_done[got_done.size() - 1] !== 1'b1 || got_key[got_key.size() - 1] !== 1'b1 ||
        count_ones(1'b1) != 1) begin
      n_fail++;
      $display("FAIL single_done: got done pulses %0d last key_n %b, want 1 pulse with key_n 1",
               count_ones(1'b1), got_key[got_key.size() - 1]);
    end
    n_checks++;
    if (count_ones(1'b0) != 0) begin
      n_fail++;
      $display("FAIL single_busy_ready: got ready high on %0d busy cycles want 0", count_ones(1'b0));
    end
    @(negedge clk);
    n_checks++;
    if ({bus.key_n, bus.ready, bus.busy, bus.done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL ready_after_done: got key_n/ready/busy/done=%b want 1100",
               {bus.key_n, bus.ready, bus.busy, bus.done});
    end
  endtask

  task automatic test_bounce_press();
    bit cut;
    build_exp(8'd10);
    start_press(8'd10);
    capture(-1, 1'b0, cut);
    n_checks++;
    if (got_key.size() !== exp_key.size() || first_diff() != -1) begin
      n_fail++;
      $display("FAIL bounce_wave: got %0d cycles first diff %0d, want %0d cycles no diff",
               got_key.size(), first_diff(), exp_key.size());
    end
    n_checks++;
    if (count_falls() != EXP_FALLS) begin
      n_fail++;
      $display("FAIL bounce_falls: got %0d falling edges want %0d", count_falls(), EXP_FALLS);
    end
    n_checks++;
    if (max_low_run() != 40) begin
      n_fail++;
      $display("FAIL bounce_hold: got longest low %0d cycles want 40", max_low_run());
    end
    n_checks++;
    if (run_at(0) != LEAD_LOW) begin
      n_fail++;
      $display("FAIL bounce_first_seg: got first low %0d cycles want %0d", run_at(0), LEAD_LOW);
    end
  endtask

  task automatic test_hold_zero();
    bit cut;
    build_exp(8'd0);
    start_press(8'd0);
    capture(-1, 1'b0, cut);
    n_checks++;
    if (run_at(exp_press_len) != 4) begin
      n_fail++;
      $display("FAIL hold_zero: got hold %0d cycles want 4", run_at(exp_press_len));
    end
    n_checks++;
    if (got_key.size() !== exp_key.size() || first_diff() != -1) begin
      n_fail++;
      $display("FAIL hold_zero_wave: got %0d cycles first diff %0d, want %0d cycles no diff",
               got_key.size(), first_diff(), exp_key.size());
    end
  endtask

  task automatic test_ignore_start();
    bit cut;
    int bad;
    build_exp(8'd10);
    start_press(8'd10);
    capture(exp_press_len + 5, 1'b0, cut);
    n_checks++;
    if (got_key.size() !== exp_key.size() || first_diff() != -1) begin
      n_fail++;
      $display("FAIL ignore_wave: got %0d cycles first diff %0d, want %0d cycles no diff",
               got_key.size(), first_diff(), exp_key.size());
    end
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if ({bus.key_n, bus.ready, bus.done} !== 3'b110) bad++;
    end
    n_checks++;
    if (bad != 0 || count_ones(1'b1) != 1) begin
      n_fail++;
      $display("FAIL ignore_start: got %0d non-idle cycles after done, %0d done pulses; want 0 and 1",
               bad, count_ones(1'b1));
    end
  endtask

  task automatic test_back_to_back();
    bit cut;
    build_exp(8'd3);
    start_press(8'd3);
    capture(-1, 1'b0, cut);
    n_checks++;
    if (got_key.size() !== exp_key.size() || first_diff() != -1) begin
      n_fail++;
      $display("FAIL b2b_first: got %0d cycles first diff %0d, want %0d cycles no diff",
               got_key.size(), first_diff(), exp_key.size());
    end
    @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b1 || bus.key_n !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle: got ready=%b key_n=%b want 1 1", bus.ready, bus.key_n);
    end
    bus.start = 1'b1;
    bus.hold_ticks = 8'd3;
    build_exp(8'd3);
    @(posedge clk);
    #1 bus.start = 1'b0;
    capture(-1, 1'b0, cut);
    n_checks++;
    if (got_key[0] !== 1'b0 || got_rdy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got key_n=%b ready=%b after restart want 0 0", got_key[0], got_rdy[0]);
    end
    n_checks++;
    if (got_key.size() !== exp_key.size() || first_diff() != -1) begin
      n_fail++;
      $display("FAIL b2b_second: got %0d cycles first diff %0d, want %0d cycles no diff",
               got_key.size(), first_diff(), exp_key.size());
    end
  endtask

  task automatic test_reset_mid();
    bit cut;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
    m_lfsr = SEED;
`endif
    build_exp(8'd6);
    start_press(8'd6);
    capture(exp_key.size() - 3, 1'b1, cut);
    @(negedge clk);
    n_checks++;
    if (!cut || {bus.key_n, bus.ready, bus.busy, bus.done} !== 4'b1100 || count_ones(1'b1) != 0) begin
      n_fail++;
      $display("FAIL reset_mid: got key_n/ready/busy/done=%b, %0d done pulses; want 1100 and 0",
               {bus.key_n, bus.ready, bus.busy, bus.done}, count_ones(1'b1));
    end
    n_checks++;
    if (first_diff() != -1) begin
      n_fail++;
      $display("FAIL reset_mid_prefix: key_n differs at cycle N+%0d", first_diff() + 1);
    end
    rst = 1'b0;
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
    m_lfsr = SEED;
`endif
    build_exp(8'd6);
    start_press(8'd6);
    capture(-1, 1'b0, cut);
    n_checks++;
    if (got_key.size() !== exp_key.size() || first_diff() != -1) begin
      n_fail++;
      $display("FAIL reset_replay: got %0d cycles first diff %0d, want %0d cycles no diff",
               got_key.size(), first_diff(), exp_key.size());
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.hold_ticks = 8'd0;
    test_reset();
    test_single_press();
    test_bounce_press();
    test_hold_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end
endmodule
